// File: rtl/chunked_add_seq.sv
// Multi-precision adder: one DATA_WIDTH-bit adder is reused per chunk, LSB chunk first.
// The carry between chunks lives only in r_carry, so there is never a wide ripple chain.
module chunked_add_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0]   a,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0]   b,
    input  logic                               cin,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*NUM_CHUNKS-1:0]   sum,
    output logic                               cout,
    output logic                               busy
);

    localparam int TW = DATA_WIDTH * NUM_CHUNKS;
    localparam int IW = $clog2(NUM_CHUNKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_a;
    logic [TW-1:0]         r_b;
    logic [TW-1:0]         r_sum;
    logic                  r_carry;
    logic                  r_cout;
    logic [IW-1:0]         r_idx;

    logic [DATA_WIDTH-1:0] w_a_chunk;
    logic [DATA_WIDTH-1:0] w_b_chunk;
    logic [DATA_WIDTH:0]   w_chunk_sum;

    // Shared chunk adder: selected operand slices plus the registered carry.
    always_comb begin
        w_a_chunk   = r_a[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_b_chunk   = r_b[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{DATA_WIDTH{1'b0}}, r_carry};
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_chunk_sum[DATA_WIDTH-1:0];
                    r_carry <= w_chunk_sum[DATA_WIDTH];
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == IW'(NUM_CHUNKS - 1)) begin
                        r_cout  <= w_chunk_sum[DATA_WIDTH];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is held low for as long as reset is asserted.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
